// File: rtl/node_pkg.sv
// Shared types, defaults and helpers for the node result collector.
// Contents: collector FSM state enum, default window/tag widths, popcount helper.
// No ports; imported by node_result_collector and its sub-module.
package node_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        TAIL   = 2'd2,
        COMMIT = 2'd3
    } state_t;

    localparam int NODE_WINDOW_DEF = 4;
    localparam int NODE_TAG_W_DEF  = 4;

    // Number of set bits in a vector of up to 32 nodes.
    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/node_result_collector_fifo.sv
// result_fifo2: 2-entry FIFO of parameterised width, head presented directly.
// Ports: clk, rst (async active-low), push/push_dat, pop, full, empty, head_dat.
// Push while full is only taken when a pop happens on the same edge.
module result_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head_dat
);

    logic [W-1:0] mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   count;
    logic         do_push;
    logic         do_pop;

    assign full     = (count == 2'd2);
    assign empty    = (count == 2'd0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            // When full, wr_ptr equals rd_ptr; writing the slot being popped is safe
            // because the new head is the other slot.
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= !wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= !rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/node_result_collector.sv
// Drives `high` to open each node's window, ORs node pulses into a hit vector and queues {vec, tag}.
// Ports: clk, rst (async active-low), start, node_out in; high, busy out; res_* valid/ready result stream; overflow.
// Optional NODE_RESULT_POPCOUNT_EN adds res_count (set bits of res_vec), stored with each entry.
module node_result_collector
    import node_pkg::*;
#(
    parameter int N_NODES = 8,
    parameter int WINDOW  = NODE_WINDOW_DEF,
    parameter int TAG_W   = NODE_TAG_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_NODES-1:0] node_out,
    output logic               high,
    output logic               busy,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [N_NODES-1:0] res_vec,
    output logic [TAG_W-1:0]   res_tag,
`ifdef NODE_RESULT_POPCOUNT_EN
    output logic [$clog2(N_NODES+1)-1:0] res_count,
`endif
    output logic               overflow
);

    localparam int CNT_W = $clog2(N_NODES + 1);
`ifdef NODE_RESULT_POPCOUNT_EN
    localparam int ENT_W = N_NODES + TAG_W + CNT_W;
`else
    localparam int ENT_W = N_NODES + TAG_W;
`endif

    state_t             state;
    logic [7:0]         wcnt;
    logic [N_NODES-1:0] acc;
    logic [TAG_W-1:0]   round;
    logic               push_q;
    logic [ENT_W-1:0]   push_ent;
    logic [ENT_W-1:0]   head_ent;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic [ENT_W-1:0]   commit_ent;

`ifdef NODE_RESULT_POPCOUNT_EN
    logic [5:0] pc_full;
    assign pc_full    = popcount(32'(acc));
    assign commit_ent = {pc_full[CNT_W-1:0], acc, round};
    assign res_count  = head_ent[ENT_W-1 -: CNT_W];
`else
    assign commit_ent = {acc, round};
`endif

    assign res_valid = !fifo_empty;
    assign pop       = res_valid && res_ready;
    assign res_tag   = head_ent[TAG_W-1:0];
    assign res_vec   = head_ent[TAG_W +: N_NODES];

    // The entry built in COMMIT is registered and pushed on the following edge,
    // so the full/pop decision is taken against the buffer at push time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wcnt     <= '0;
            acc      <= '0;
            round    <= '0;
            high     <= 1'b0;
            busy     <= 1'b0;
            push_q   <= 1'b0;
            push_ent <= '0;
            overflow <= 1'b0;
        end else begin
            push_q <= 1'b0;
            if (push_q && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= '0;
                        wcnt  <= '0;
                        state <= ARM;
                        high  <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                ARM: begin
                    acc <= acc | node_out;
                    if (wcnt == 8'(WINDOW - 1)) begin
                        state <= TAIL;
                        high  <= 1'b0;
                    end else begin
                        wcnt <= wcnt + 8'd1;
                    end
                end
                TAIL: begin
                    // Catches a node pulse registered on the last ARM edge.
                    acc   <= acc | node_out;
                    state <= COMMIT;
                end
                COMMIT: begin
                    push_q   <= 1'b1;
                    push_ent <= commit_ent;
                    round    <= round + 1'b1;
                    state    <= IDLE;
                    busy     <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    high  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    result_fifo2 #(.W(ENT_W)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_q),
        .push_dat (push_ent),
        .pop      (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head_dat (head_ent)
    );

endmodule

// File: tb/tb_node_result_collector.sv
module tb_node_result_collector;

    localparam int N   = 8;
    localparam int WIN = 4;
    localparam int TW  = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] node_out;
    logic         high;
    logic         busy;
    logic         res_valid;
    logic         res_ready;
    logic [N-1:0] res_vec;
    logic [TW-1:0] res_tag;
    logic         overflow;
`ifdef NODE_RESULT_POPCOUNT_EN
    logic [3:0]   res_count;
`endif

    int compared   = 0;
    int mismatched = 0;

    node_result_collector #(.N_NODES(N), .WINDOW(WIN), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .node_out  (node_out),
        .high      (high),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_vec   (res_vec),
        .res_tag   (res_tag),
`ifdef NODE_RESULT_POPCOUNT_EN
        .res_count (res_count),
`endif
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        step();
    endtask

    // Start a round with node_out idle; returns after the entry becomes visible.
    task automatic run_round();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (WIN + 3) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        node_out  = '0;
        res_ready = 1'b0;
        #3;
        chk("rst_high", 32'(high), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(res_valid), 0);
        chk("rst_vec", 32'(res_vec), 0);
        chk("rst_tag", 32'(res_tag), 0);
        chk("rst_ovf", 32'(overflow), 0);
`ifdef NODE_RESULT_POPCOUNT_EN
        chk("rst_count", 32'(res_count), 0);
`endif
        rst = 1'b1;
        step();

        // Round 0: node_out active in IDLE and COMMIT only -> must be ignored.
        node_out = 8'hFF;
        start    = 1'b1;
        step();
        start    = 1'b0;
        node_out = '0;
        chk("r0_high_0", 32'(high), 1);
        chk("r0_busy_0", 32'(busy), 1);
        for (int i = 1; i <= WIN + 3; i++) begin
            node_out = (i == WIN + 2) ? 8'hFF : 8'h00;
            step();
            chk($sformatf("r0_high_%0d", i), 32'(high), (i < WIN) ? 1 : 0);
            chk($sformatf("r0_busy_%0d", i), 32'(busy), (i < WIN + 2) ? 1 : 0);
            chk($sformatf("r0_valid_%0d", i), 32'(res_valid), (i >= WIN + 3) ? 1 : 0);
        end
        node_out = '0;
        chk("r0_vec", 32'(res_vec), 32'h00);
        chk("r0_tag", 32'(res_tag), 0);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("r0_pop_valid", 32'(res_valid), 0);

        // Round 1: bit 5 on the last ARM cycle, bit 0 in TAIL.
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (WIN - 1) step();
        node_out = 8'h20;
        step();
        node_out = 8'h01;
        step();
        node_out = 8'h00;
        step();
        step();
        chk("r1_valid", 32'(res_valid), 1);
        chk("r1_vec", 32'(res_vec), 32'h21);
        chk("r1_tag", 32'(res_tag), 1);
`ifdef NODE_RESULT_POPCOUNT_EN
        chk("r1_count", 32'(res_count), 2);
`endif
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;

        // Full buffer with a pop on the push edge: push accepted, no overflow.
        do_reset();
        run_round();
        run_round();
        chk("fp_ovf_pre", 32'(overflow), 0);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (WIN + 2) step();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("fp_valid", 32'(res_valid), 1);
        chk("fp_head_tag", 32'(res_tag), 1);
        chk("fp_ovf", 32'(overflow), 0);
        res_ready = 1'b1;
        step();
        chk("fp_next_tag", 32'(res_tag), 2);
        step();
        res_ready = 1'b0;
        chk("fp_empty", 32'(res_valid), 0);

        // Three rounds without draining: third dropped, overflow sticky.
        do_reset();
        run_round();
        run_round();
        run_round();
        chk("of_valid", 32'(res_valid), 1);
        chk("of_tag0", 32'(res_tag), 0);
        chk("of_ovf", 32'(overflow), 1);
        res_ready = 1'b1;
        step();
        chk("of_tag1", 32'(res_tag), 1);
        chk("of_valid1", 32'(res_valid), 1);
        step();
        chk("of_empty", 32'(res_valid), 0);
        res_ready = 1'b0;
        run_round();
        chk("of_next_tag", 32'(res_tag), 3);
        chk("of_ovf_sticky", 32'(overflow), 1);

        // Reset during the second ARM cycle with an entry still buffered.
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        #2;
        rst = 1'b0;
        #1;
        chk("mr_high", 32'(high), 0);
        chk("mr_busy", 32'(busy), 0);
        chk("mr_valid", 32'(res_valid), 0);
        chk("mr_ovf", 32'(overflow), 0);
        rst = 1'b1;
        step();
        run_round();
        chk("mr_valid_after", 32'(res_valid), 1);
        chk("mr_tag", 32'(res_tag), 0);
        res_ready = 1'b1;
        step();

        // Continuous start for 40 rounds: one round per WIN+3 cycles, tags wrap.
        begin
            int n;
            logic [TW-1:0] exp_tag;
            n     = 0;
            start = 1'b1;
            for (int c = 0; c < 40 * (WIN + 3) + 12; c++) begin
                step();
                if (c == 40 * (WIN + 3) - 1) start = 1'b0;
                if (res_valid) begin
                    exp_tag = TW'(1 + n);
                    chk($sformatf("ct_tag_%0d", n), 32'(res_tag), 32'(exp_tag));
                    n++;
                end
            end
            chk("ct_rounds", n, 40);
            chk("ct_ovf", 32'(overflow), 0);
            chk("ct_busy_end", 32'(busy), 0);
        end
        res_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
